wb8_bus_master: RTL and testbench

Single-outstanding bus initiator for the 8-bit strobe/ack register bus that the USB slave core exposes as a responder (address_i, data_i, data_o, we_i, strobe_i, ack_o).
- Accepts read/write commands on a valid/ready port and runs exactly one bus cycle per command.
- Returns read data and a timeout flag on a valid/ready response port.
- Sits between a local controller (CPU-less sequencer or test harness) and the USB slave register file.

---
 rtl/wb8_pkg.sv | 14 +
 rtl/wb8_bus_master.sv | 105 ++++++++++
 tb/tb_wb8_bus_master.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/wb8_pkg.sv
// Shared types and constants for the 8-bit strobe/ack register bus initiator.
package wb8_pkg;

  localparam int ADDR_W          = 8;
  localparam int DATA_W          = 8;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } wb8_state_e;

endpackage

// File: rtl/wb8_bus_master.sv
// Single-outstanding initiator: one strobe/ack bus cycle per accepted command,
// result (read data or timeout) returned on a valid/ready response port.
module wb8_bus_master
  import wb8_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int TO_WIDTH       = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] address_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              we_o,
  output logic              strobe_o,
  input  logic              ack_i,
  output logic              busy
);

  localparam logic [TO_WIDTH-1:0] CNT_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  wb8_state_e          state, state_next;
  logic [TO_WIDTH-1:0] cnt;
  logic                accept, ack_hit, to_hit, release_rsp;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    ack_hit     = 1'b0;
    to_hit      = 1'b0;
    release_rsp = 1'b0;
    unique case (state)
      IDLE: begin
        accept = cmd_valid;
        if (cmd_valid) state_next = BUS;
      end
      BUS: begin
        // An ack in the final counted cycle takes priority over the timeout.
        ack_hit = ack_i;
        to_hit  = !ack_i && (cnt == CNT_LAST);
        if (ack_hit || to_hit) state_next = RSP;
      end
      RSP: begin
        release_rsp = rsp_ready;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt         <= '0;
      strobe_o    <= 1'b0;
      we_o        <= 1'b0;
      address_o   <= '0;
      data_o      <= '0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      if (accept) begin
        address_o <= cmd_addr;
        data_o    <= cmd_we ? cmd_wdata : '0;
        we_o      <= cmd_we;
        strobe_o  <= 1'b1;
        cnt       <= '0;
      end else if (ack_hit) begin
        strobe_o    <= 1'b0;
        we_o        <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_timeout <= 1'b0;
        rsp_rdata   <= we_o ? '0 : data_i;
      end else if (to_hit) begin
        strobe_o    <= 1'b0;
        we_o        <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_timeout <= 1'b1;
        rsp_rdata   <= '0;
      end else if (state == BUS) begin
        cnt <= cnt + 1'b1;
      end else if (release_rsp) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb8_bus_master.sv
// Directed and randomized bench for wb8_bus_master with a transaction-level
// reference model of strobe length, timeout and returned data.
module tb_wb8_bus_master;

  localparam int TO = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cmd_valid, cmd_we, rsp_ready, ack_i;
  logic [7:0] cmd_addr, cmd_wdata, data_i;
  logic       cmd_ready, rsp_valid, rsp_timeout, we_o, strobe_o, busy;
  logic [7:0] rsp_rdata, address_o, data_o;

  int vectors = 0;
  int errors  = 0;
  int strobe_rises = 0;

  wb8_bus_master #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .address_o(address_o), .data_o(data_o), .data_i(data_i),
    .we_o(we_o), .strobe_o(strobe_o), .ack_i(ack_i), .busy(busy)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge strobe_o) strobe_rises++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, DUT idle again.
  // ack_on: strobe cycle (1-based) in which the responder acks, 0 = never.
  task automatic run_cmd(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input int ack_on, input logic [7:0] rdata, input int hold);
    int         n;
    int         exp_len;
    logic       exp_to;
    logic [7:0] exp_rd;
    exp_to  = (ack_on == 0) || (ack_on > TO);
    exp_len = exp_to ? TO : ack_on;
    exp_rd  = (exp_to || we) ? 8'h00 : rdata;

    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
    @(negedge clk_i);
    cmd_valid = 1'b0; cmd_we = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;
    check("strobe_start", strobe_o, 1);
    n = 0;
    while (strobe_o === 1'b1 && n < 50) begin
      n++;
      check("address_hold", address_o, addr);
      check("data_hold", data_o, we ? wdata : 8'h00);
      check("we_hold", we_o, we);
      check("cmd_ready_busy", cmd_ready, 0);
      if (n == ack_on) begin ack_i = 1'b1; data_i = rdata; end
      else begin ack_i = 1'b0; data_i = $urandom; end
      @(negedge clk_i);
    end
    ack_i = 1'b0;
    check("strobe_len", n, exp_len);
    check("we_after", we_o, 0);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_timeout", rsp_timeout, exp_to);
    check("rsp_rdata", rsp_rdata, exp_rd);
    for (int h = 0; h < hold; h++) begin
      ack_i = $urandom; data_i = $urandom;
      @(negedge clk_i);
      ack_i = 1'b0;
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_timeout", rsp_timeout, exp_to);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_strobe", strobe_o, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk_i);
    rsp_ready = 1'b0;
    check("rsp_released", rsp_valid, 0);
    check("idle_after_rsp", cmd_ready, 1);
    check("busy_after_rsp", busy, 0);
  endtask

  initial begin
    int rises0;
    rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; ack_i = 1'b0; data_i = '0;
    #1;
    check("rst_strobe", strobe_o, 0);
    check("rst_we", we_o, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_addr", address_o, 0);
    check("rst_data", data_o, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed cases from the plan
    run_cmd(1'b1, 8'h05, 8'hA5, 1, 8'h00, 0);
    run_cmd(1'b0, 8'h10, 8'h00, 4, 8'h3C, 0);
    run_cmd(1'b0, 8'h22, 8'h00, 0, 8'h00, 1);
    // late ack after timeout, now idle: must not start anything
    ack_i = 1'b1;
    @(negedge clk_i);
    ack_i = 1'b0;
    check("late_ack_strobe", strobe_o, 0);
    check("late_ack_valid", rsp_valid, 0);
    check("late_ack_busy", busy, 0);
    run_cmd(1'b0, 8'h33, 8'h00, TO, 8'h77, 0);
    run_cmd(1'b0, 8'h44, 8'h00, 2, 8'h9E, 5);

    // Back-to-back commands: one strobe per command
    rises0 = strobe_rises;
    run_cmd(1'b1, 8'h50, 8'h11, 1, 8'h00, 0);
    run_cmd(1'b0, 8'h51, 8'h00, 1, 8'h22, 0);
    run_cmd(1'b1, 8'h52, 8'h33, 1, 8'h00, 0);
    check("b2b_strobes", strobe_rises - rises0, 3);

    // Reset in the middle of a bus cycle
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h7F;
    @(negedge clk_i);
    cmd_valid = 1'b0;
    check("pre_rst_strobe", strobe_o, 1);
    rst_i = 1'b1;
    #1;
    check("midrst_strobe", strobe_o, 0);
    check("midrst_valid", rsp_valid, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_valid", rsp_valid, 0);
    run_cmd(1'b0, 8'h01, 8'h00, 2, 8'hC3, 0);

    // Randomized commands against the reference model
    for (int i = 0; i < 30; i++) begin
      run_cmd(1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, TO + 2),
              8'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog expired");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

endmodule
